uart_rx: RTL and testbench

- UART receiver; the downstream stage of the Tx block.
- Consumes the serial line driven by Tx serial_data_out, rebuilds 5–8-bit characters and checks parity and stop bit.
- Presents each character as a one-cycle valid pulse with error flags.
- Runtime config (data_length, parity_type, baud_rate) uses the same encodings as Tx, so both ends can share one config source.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_baud_gen.sv | 24 ++
 rtl/uart_rx.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity/baud encodings, baud divisor helper and length limits.
// Used by both the receiver and the transmitter so one config source drives both ends.
package uart_pkg;

  typedef enum logic [1:0] {
    ParEven = 2'd0,
    ParOdd  = 2'd1,
    ParNone = 2'd2
  } parity_e;

  typedef enum logic [1:0] {
    Baud4800  = 2'd0,
    Baud9600  = 2'd1,
    Baud19200 = 2'd2,
    Baud38400 = 2'd3
  } baud_e;

  localparam int unsigned BAUD_4800  = 4800;
  localparam int unsigned BAUD_9600  = 9600;
  localparam int unsigned BAUD_19200 = 19200;
  localparam int unsigned BAUD_38400 = 38400;

  localparam int unsigned DATA_LEN_MIN = 5;
  localparam int unsigned DATA_LEN_MAX = 8;

  localparam int unsigned DivW = 16;

  function automatic logic [DivW-1:0] baud_div(input int unsigned clk_hz, input logic [1:0] sel,
                                               input int unsigned oversample);
    int unsigned baud;
    case (sel)
      2'd0:    baud = BAUD_4800;
      2'd1:    baud = BAUD_9600;
      2'd2:    baud = BAUD_19200;
      default: baud = BAUD_38400;
    endcase
    return DivW'(clk_hz / (baud * oversample));
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle tick every div_i clocks, held at phase zero by clear_i.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic [DivW-1:0] div_i,
  output logic            tick_o
);

  logic [DivW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = !clear_i && ((cnt_q + DivW'(1)) >= div_i);
    cnt_d  = (clear_i || tick_o) ? '0 : cnt_q + DivW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop line sync, 16x oversampled framing FSM, parity/stop checks and
// a one-cycle valid pulse with held error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_data_in,
  input  logic [3:0] data_length,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StWaitIdle
  } state_e;

  localparam logic [DivW-1:0] Div0 = baud_div(CLK_HZ, 2'd0, OVERSAMPLE);
  localparam logic [DivW-1:0] Div1 = baud_div(CLK_HZ, 2'd1, OVERSAMPLE);
  localparam logic [DivW-1:0] Div2 = baud_div(CLK_HZ, 2'd2, OVERSAMPLE);
  localparam logic [DivW-1:0] Div3 = baud_div(CLK_HZ, 2'd3, OVERSAMPLE);

  state_e          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [3:0]      len_q, len_d;
  parity_e         par_q, par_d;
  logic [1:0]      baud_q, baud_d;
  logic [3:0]      tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_ok_q, parity_ok_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            valid_q, valid_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            busy_q, busy_d;
  logic            rx_s;
  logic            tick;
  logic [DivW-1:0] div;

  assign rx_s = sync_q[1];

  always_comb begin
    case (baud_q)
      2'd0:    div = Div0;
      2'd1:    div = Div1;
      2'd2:    div = Div2;
      default: div = Div3;
    endcase
  end

  // Divider held cleared in IDLE so tick phase starts at the detected start edge.
  uart_baud_gen u_baud_gen (
    .clk_i   (clk),
    .rst_i   (reset),
    .clear_i (state_q == StIdle),
    .div_i   (div),
    .tick_o  (tick)
  );

  always_comb begin
    sync_d      = {sync_q[0], serial_data_in};
    state_d     = state_q;
    len_d       = len_q;
    par_d       = par_q;
    baud_d      = baud_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    parity_ok_d = parity_ok_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    perr_d      = perr_q;
    ferr_d      = ferr_q;

    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d     = StStart;
          tick_cnt_d  = '0;
          shift_d     = '0;
          parity_ok_d = 1'b1;
          baud_d      = baud_rate;
          len_d       = (data_length >= 4'(DATA_LEN_MIN) && data_length <= 4'(DATA_LEN_MAX)) ?
                        data_length : 4'(DATA_LEN_MAX);
          par_d       = (parity_type == 2'd3) ? ParNone : parity_e'(parity_type);
        end
      end
      StStart: begin
        if (tick) begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = rx_s ? StIdle : StData;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d[bit_idx_q] = rx_s;
            if ({1'b0, bit_idx_q} == len_q - 4'd1) begin
              state_d = (par_q == ParNone) ? StStop : StParity;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
      end
      StParity: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            parity_ok_d = ((^shift_q) ^ rx_s) == (par_q == ParOdd);
            state_d     = StStop;
          end
        end
      end
      StStop: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            valid_d    = 1'b1;
            data_out_d = shift_q & (8'hFF >> (4'd8 - len_q));
            perr_d     = !parity_ok_q;
            ferr_d     = !rx_s;
            state_d    = rx_s ? StIdle : StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      sync_q      <= 2'b11;
      len_q       <= 4'(DATA_LEN_MAX);
      par_q       <= ParNone;
      baud_q      <= '0;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      parity_ok_q <= 1'b1;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      len_q       <= len_d;
      par_q       <= par_d;
      baud_q      <= baud_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      parity_ok_q <= parity_ok_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
    end
  end

  assign data_out      = data_out_q;
  assign valid         = valid_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bench-driven serial frames compared against a
// frame-level reference model (bit period = CLK_HZ / baud).
module tb_uart_rx;

  localparam int unsigned ClkHz = 1_228_800;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_data_in;
  logic [3:0] data_length;
  logic [1:0] parity_type;
  logic [1:0] baud_rate;
  logic [7:0] data_out;
  logic       valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_HZ     (ClkHz),
    .OVERSAMPLE (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .serial_data_in (serial_data_in),
    .data_length    (data_length),
    .parity_type    (parity_type),
    .baud_rate      (baud_rate),
    .data_out       (data_out),
    .valid          (valid),
    .parity_error   (parity_error),
    .framing_error  (framing_error),
    .busy           (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Captured results: {framing_error, parity_error, data_out} at each valid.
  logic [9:0] rx_q[$];
  int         nvalid = 0;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      rx_q.push_back({framing_error, parity_error, data_out});
      nvalid++;
    end
  end

  function automatic int bit_clks(input logic [1:0] b);
    return int'(ClkHz / (4800 << b));
  endfunction

  task automatic drive_bit(input logic b, input int clks);
    serial_data_in = b;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [7:0] data, input int len, input bit par_en,
                             input bit par_bit, input bit stop, input int bclk,
                             input bit scramble);
    drive_bit(1'b0, bclk / 2);
    if (scramble) begin
      data_length = 4'($urandom);
      parity_type = 2'($urandom);
      baud_rate   = 2'($urandom);
    end
    drive_bit(1'b0, bclk - bclk / 2);
    for (int i = 0; i < len; i++) drive_bit(data[i], bclk);
    if (par_en) drive_bit(par_bit, bclk);
    drive_bit(stop, bclk);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] data, input logic [3:0] len_cfg,
                           input logic [1:0] par_cfg, input logic [1:0] baud_cfg,
                           input bit flip_par, input bit stop, input int gap_bits);
    int         len;
    bit         par_en;
    bit         par_bit;
    logic [7:0] exp_data;
    bit         exp_pe;
    int         start;
    logic [9:0] got;
    len      = (len_cfg >= 5 && len_cfg <= 8) ? int'(len_cfg) : 8;
    par_en   = (par_cfg == 2'd0 || par_cfg == 2'd1);
    exp_data = data & 8'((1 << len) - 1);
    par_bit  = ((^exp_data) ^ (par_cfg == 2'd1)) ^ flip_par;
    exp_pe   = par_en && flip_par;
    data_length = len_cfg;
    parity_type = par_cfg;
    baud_rate   = baud_cfg;
    rx_q.delete();
    start = nvalid;
    drive_frame(data, len, par_en, par_bit, stop, bit_clks(baud_cfg), 1'b1);
    check({tag, ".count"}, nvalid - start, 1);
    if (rx_q.size() > 0) begin
      got = rx_q.pop_front();
      check({tag, ".data"}, got[7:0], exp_data);
      check({tag, ".perr"}, got[8], exp_pe);
      check({tag, ".ferr"}, got[9], !stop);
    end
    check({tag, ".held_perr"}, parity_error, exp_pe);
    drive_bit(1'b1, gap_bits * bit_clks(baud_cfg));
  endtask

  initial begin
    logic [7:0] d;
    logic [3:0] l;
    logic [1:0] p;
    logic [1:0] b;
    bit         fp;
    bit         st;
    int         start;
    int         n;
    logic [9:0] got;

    reset = 1'b1;
    serial_data_in = 1'b1;
    data_length = 4'd8;
    parity_type = 2'd0;
    baud_rate = 2'd3;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst.data", data_out, 8'h00);
    check("rst.valid", valid, 1'b0);
    check("rst.perr", parity_error, 1'b0);
    check("rst.ferr", framing_error, 1'b0);
    check("rst.busy", busy, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    drive_bit(1'b1, 20);

    // Loopback-style frames, parity sweep and mismatched parity.
    run_frame("even81", 8'h81, 4'd8, 2'd0, 2'd3, 1'b0, 1'b1, 1);
    run_frame("even83", 8'h83, 4'd8, 2'd0, 2'd3, 1'b0, 1'b1, 0);
    run_frame("odd81", 8'h81, 4'd8, 2'd1, 2'd3, 1'b0, 1'b1, 1);
    run_frame("none83", 8'h83, 4'd8, 2'd2, 2'd3, 1'b0, 1'b1, 1);
    run_frame("perr81", 8'h81, 4'd8, 2'd0, 2'd3, 1'b1, 1'b1, 1);
    run_frame("perr83", 8'h83, 4'd8, 2'd0, 2'd3, 1'b1, 1'b1, 1);

    // Length sweep with all-ones data.
    for (int i = 5; i <= 8; i++) run_frame($sformatf("len%0d", i), 8'hFF, 4'(i), 2'd2, 2'd3,
                                           1'b0, 1'b1, 1);

    // Baud sweep.
    for (int i = 0; i < 4; i++) run_frame($sformatf("baud%0d", i), 8'h3C, 4'd8, 2'd2, 2'(i),
                                          1'b0, 1'b1, 1);

    // Randomized frames.
    for (int i = 0; i < 24; i++) begin
      d  = 8'($urandom);
      l  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(5, 8));
      p  = 2'($urandom);
      b  = 2'($urandom_range(1, 3));
      fp = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 4) != 0);
      run_frame($sformatf("rnd%0d", i), d, l, p, b, fp, st, st ? $urandom_range(0, 2) : 1);
    end

    // Short low glitch at baud 0 must not produce a character.
    baud_rate = 2'd0;
    start = nvalid;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 10);
    check("glitch.busy_hi", busy, 1'b1);
    drive_bit(1'b1, 300);
    check("glitch.busy_lo", busy, 1'b0);
    check("glitch.count", nvalid - start, 0);

    // Stop bit low, then line held low: one valid with framing error, no retrigger.
    data_length = 4'd8;
    parity_type = 2'd2;
    baud_rate = 2'd3;
    rx_q.delete();
    start = nvalid;
    drive_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, bit_clks(2'd3), 1'b0);
    drive_bit(1'b0, 2 * bit_clks(2'd3));
    drive_bit(1'b1, 3 * bit_clks(2'd3));
    check("brk.count", nvalid - start, 1);
    if (rx_q.size() > 0) begin
      got = rx_q.pop_front();
      check("brk.data", got[7:0], 8'h55);
      check("brk.ferr", got[9], 1'b1);
    end
    check("brk.busy", busy, 1'b0);

    // Reset in the middle of data bit 3.
    data_length = 4'd8;
    parity_type = 2'd0;
    baud_rate = 2'd2;
    start = nvalid;
    drive_bit(1'b0, bit_clks(2'd2));
    for (int i = 0; i < 3; i++) drive_bit(1'b1, bit_clks(2'd2));
    drive_bit(1'b0, bit_clks(2'd2) / 2);
    check("rstmid.busy_pre", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("rstmid.data", data_out, 8'h00);
    check("rstmid.ferr", framing_error, 1'b0);
    check("rstmid.busy", busy, 1'b0);
    check("rstmid.valid", valid, 1'b0);
    serial_data_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    drive_bit(1'b1, 20);
    check("rstmid.count", nvalid - start, 0);
    run_frame("postrst", 8'hA5, 4'd8, 2'd0, 2'd2, 1'b0, 1'b1, 1);

    // Tx at 9600 while Rx expects 4800: corrupted result, and the receiver must not hang.
    data_length = 4'd8;
    parity_type = 2'd2;
    baud_rate = 2'd0;
    rx_q.delete();
    start = nvalid;
    drive_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, bit_clks(2'd1), 1'b0);
    n = 0;
    while (busy && n < 6000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("mismatch.busy", busy, 1'b0);
    check("mismatch.count", nvalid - start, 1);
    if (rx_q.size() > 0) begin
      got = rx_q.pop_front();
      check("mismatch.bad", (got[9] || got[7:0] != 8'h3C), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
